bp_be_dcache_pkt_encoder: RTL and testbench

- Producer end of the dcache packet interface: turns RISC-V memory instructions from the BE pipeline into bp_be_dcache_pkt_s packets (opcode, vaddr, data, rd_addr).
- Buffers encoded packets in a small FIFO and hands them to the dcache over a valid/yumi handshake.
- Also handles FENCE drain ordering, pipeline flush, and flagging illegal memory encodings.

---
 rtl/bp_be_dcache_pkt_encoder_pkg.sv | 74 +++++++
 rtl/bp_be_dcache_pkt_encode.sv | 132 +++++++++++++
 rtl/bp_be_dcache_pkt_encoder.sv | 141 ++++++++++++++
 tb/tb_bp_be_dcache_pkt_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_dcache_pkt_encoder_pkg.sv
// bp_be_dcache_pkt_encoder_pkg
// Shared definitions for the BE dcache packet encoder: RISC-V major opcodes,
// funct3 / AMO funct5 codes, CBO immediates, the dcache packet format and
// the encoder FSM state type.
// No ports (package).

package bp_be_dcache_pkt_encoder_pkg;

  localparam int vaddr_width_gp = 39;
  localparam int dword_width_gp = 64;

  // RISC-V major opcodes handled by the encoder
  localparam logic [6:0] rv_op_load     = 7'b0000011;
  localparam logic [6:0] rv_op_store    = 7'b0100011;
  localparam logic [6:0] rv_op_load_fp  = 7'b0000111;
  localparam logic [6:0] rv_op_store_fp = 7'b0100111;
  localparam logic [6:0] rv_op_amo      = 7'b0101111;
  localparam logic [6:0] rv_op_misc_mem = 7'b0001111;

  // funct3 values
  localparam logic [2:0] rv_f3_w     = 3'b010;
  localparam logic [2:0] rv_f3_d     = 3'b011;
  localparam logic [2:0] rv_f3_fence = 3'b000;
  localparam logic [2:0] rv_f3_cbo   = 3'b010;

  // AMO funct5 values
  localparam logic [4:0] rv_f5_lr      = 5'b00010;
  localparam logic [4:0] rv_f5_sc      = 5'b00011;
  localparam logic [4:0] rv_f5_amoswap = 5'b00001;
  localparam logic [4:0] rv_f5_amoadd  = 5'b00000;
  localparam logic [4:0] rv_f5_amoxor  = 5'b00100;
  localparam logic [4:0] rv_f5_amoand  = 5'b01100;
  localparam logic [4:0] rv_f5_amoor   = 5'b01000;
  localparam logic [4:0] rv_f5_amomin  = 5'b10000;
  localparam logic [4:0] rv_f5_amomax  = 5'b10100;
  localparam logic [4:0] rv_f5_amominu = 5'b11000;
  localparam logic [4:0] rv_f5_amomaxu = 5'b11100;

  // CBO immediates (imm[11:0] of MISC-MEM funct3 010)
  localparam logic [11:0] rv_cbo_inval = 12'd0;
  localparam logic [11:0] rv_cbo_clean = 12'd1;
  localparam logic [11:0] rv_cbo_flush = 12'd2;
  localparam logic [11:0] rv_cbo_zero  = 12'd4;

  typedef enum logic [5:0] {
    e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
    e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu,
    e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd,
    e_dcache_op_flw, e_dcache_op_fld, e_dcache_op_fsw, e_dcache_op_fsd,
    e_dcache_op_lrw, e_dcache_op_scw,
    e_dcache_op_amoswapw, e_dcache_op_amoaddw, e_dcache_op_amoxorw,
    e_dcache_op_amoandw, e_dcache_op_amoorw, e_dcache_op_amominw,
    e_dcache_op_amomaxw, e_dcache_op_amominuw, e_dcache_op_amomaxuw,
    e_dcache_op_lrd, e_dcache_op_scd,
    e_dcache_op_amoswapd, e_dcache_op_amoaddd, e_dcache_op_amoxord,
    e_dcache_op_amoandd, e_dcache_op_amoord, e_dcache_op_amomind,
    e_dcache_op_amomaxd, e_dcache_op_amominud, e_dcache_op_amomaxud,
    e_dcache_op_binval, e_dcache_op_bclean, e_dcache_op_bflush,
    e_dcache_op_bzero
  } bp_be_dcache_opcode_e;

  typedef struct packed {
    bp_be_dcache_opcode_e        opcode;
    logic [dword_width_gp-1:0]   data;
    logic [vaddr_width_gp-1:0]   vaddr;
    logic [4:0]                  rd_addr;
  } bp_be_dcache_pkt_s;

  typedef enum logic [0:0] {
    e_run,
    e_drain
  } bp_be_encoder_state_e;

endpackage

// File: rtl/bp_be_dcache_pkt_encode.sv
// bp_be_dcache_pkt_encode
// Pure combinational decode of a raw RISC-V instruction into the dcache
// opcode plus the side information the encoder needs.
// Ports:
//   instr     in   32-bit raw instruction
//   opcode    out  dcache opcode (don't care when illegal or is_fence)
//   rd_addr   out  destination register, 0 for stores and CBOs
//   has_data  out  packet carries the rs2 source data
//   is_fence  out  instruction is a FENCE (no packet produced)
//   illegal   out  unsupported memory encoding

module bp_be_dcache_pkt_encode
  import bp_be_dcache_pkt_encoder_pkg::*;
(
  input  logic [31:0]          instr,
  output bp_be_dcache_opcode_e opcode,
  output logic [4:0]           rd_addr,
  output logic                 has_data,
  output logic                 is_fence,
  output logic                 illegal
);

  logic [6:0]  major;
  logic [2:0]  funct3;
  logic [4:0]  funct5;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm;
  logic        dword;
  logic        unused_rs1;

  assign major      = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct5     = instr[31:27];
  assign rs2        = instr[24:20];
  assign rd         = instr[11:7];
  assign imm        = instr[31:20];
  assign dword      = (funct3 == rv_f3_d);
  // rs1 is folded into vaddr upstream
  assign unused_rs1 = ^instr[19:15];

  always_comb begin
    opcode   = e_dcache_op_lb;
    rd_addr  = '0;
    has_data = 1'b0;
    is_fence = 1'b0;
    illegal  = 1'b0;
    case (major)
      rv_op_load: begin
        rd_addr = rd;
        case (funct3)
          3'b000:  opcode = e_dcache_op_lb;
          3'b001:  opcode = e_dcache_op_lh;
          3'b010:  opcode = e_dcache_op_lw;
          3'b011:  opcode = e_dcache_op_ld;
          3'b100:  opcode = e_dcache_op_lbu;
          3'b101:  opcode = e_dcache_op_lhu;
          3'b110:  opcode = e_dcache_op_lwu;
          default: illegal = 1'b1;
        endcase
      end
      rv_op_store: begin
        has_data = 1'b1;
        case (funct3)
          3'b000:  opcode = e_dcache_op_sb;
          3'b001:  opcode = e_dcache_op_sh;
          3'b010:  opcode = e_dcache_op_sw;
          3'b011:  opcode = e_dcache_op_sd;
          default: illegal = 1'b1;
        endcase
      end
      rv_op_load_fp: begin
        rd_addr = rd;
        case (funct3)
          rv_f3_w: opcode = e_dcache_op_flw;
          rv_f3_d: opcode = e_dcache_op_fld;
          default: illegal = 1'b1;
        endcase
      end
      rv_op_store_fp: begin
        has_data = 1'b1;
        case (funct3)
          rv_f3_w: opcode = e_dcache_op_fsw;
          rv_f3_d: opcode = e_dcache_op_fsd;
          default: illegal = 1'b1;
        endcase
      end
      rv_op_amo: begin
        rd_addr  = rd;
        has_data = 1'b1;
        // Only word and double widths exist for AMOs
        if ((funct3 != rv_f3_w) && (funct3 != rv_f3_d)) illegal = 1'b1;
        case (funct5)
          rv_f5_lr: begin
            opcode   = dword ? e_dcache_op_lrd : e_dcache_op_lrw;
            has_data = 1'b0;
            // lr has no source operand, so a nonzero rs2 is reserved
            if (rs2 != 5'd0) illegal = 1'b1;
          end
          rv_f5_sc:      opcode = dword ? e_dcache_op_scd      : e_dcache_op_scw;
          rv_f5_amoswap: opcode = dword ? e_dcache_op_amoswapd : e_dcache_op_amoswapw;
          rv_f5_amoadd:  opcode = dword ? e_dcache_op_amoaddd  : e_dcache_op_amoaddw;
          rv_f5_amoxor:  opcode = dword ? e_dcache_op_amoxord  : e_dcache_op_amoxorw;
          rv_f5_amoand:  opcode = dword ? e_dcache_op_amoandd  : e_dcache_op_amoandw;
          rv_f5_amoor:   opcode = dword ? e_dcache_op_amoord   : e_dcache_op_amoorw;
          rv_f5_amomin:  opcode = dword ? e_dcache_op_amomind  : e_dcache_op_amominw;
          rv_f5_amomax:  opcode = dword ? e_dcache_op_amomaxd  : e_dcache_op_amomaxw;
          rv_f5_amominu: opcode = dword ? e_dcache_op_amominud : e_dcache_op_amominuw;
          rv_f5_amomaxu: opcode = dword ? e_dcache_op_amomaxud : e_dcache_op_amomaxuw;
          default:       illegal = 1'b1;
        endcase
      end
      rv_op_misc_mem: begin
        case (funct3)
          rv_f3_fence: is_fence = 1'b1;
          rv_f3_cbo: begin
            case (imm)
              rv_cbo_inval: opcode = e_dcache_op_binval;
              rv_cbo_clean: opcode = e_dcache_op_bclean;
              rv_cbo_flush: opcode = e_dcache_op_bflush;
              rv_cbo_zero:  opcode = e_dcache_op_bzero;
              default:      illegal = 1'b1;
            endcase
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bp_be_dcache_pkt_encoder.sv
// bp_be_dcache_pkt_encoder
// Turns BE memory instructions into dcache packets, buffers them in a small
// FIFO and presents the head over a valid/yumi handshake. FENCE stalls
// acceptance until the buffer drains; flush discards buffered packets.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   v_i / ready_o    instruction handshake (accept = v_i & ready_o)
//   instr_i          raw instruction
//   vaddr_i          effective address
//   data_i           rs2 source data
//   flush_i          discard all buffered packets
//   illegal_o        pulse: accepted instruction was an unsupported encoding
//   fence_done_o     pulse: accepted FENCE completed
//   pkt_v_o / pkt_o  head packet valid / head packet
//   pkt_yumi_i       dcache consumes the head packet

module bp_be_dcache_pkt_encoder
  import bp_be_dcache_pkt_encoder_pkg::*;
#(
  parameter int buf_els_p = 2
)
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [31:0]               instr_i,
  input  logic [vaddr_width_gp-1:0] vaddr_i,
  input  logic [dword_width_gp-1:0] data_i,
  input  logic                      flush_i,
  output logic                      illegal_o,
  output logic                      fence_done_o,
  output logic                      pkt_v_o,
  output bp_be_dcache_pkt_s         pkt_o,
  input  logic                      pkt_yumi_i
);

  localparam int ptr_w = (buf_els_p > 1) ? $clog2(buf_els_p) : 1;
  localparam int cnt_w = $clog2(buf_els_p + 1);

  bp_be_dcache_opcode_e dec_opcode;
  logic [4:0]           dec_rd_addr;
  logic                 dec_has_data;
  logic                 dec_fence;
  logic                 dec_illegal;

  bp_be_dcache_pkt_encode encode (
    .instr    (instr_i),
    .opcode   (dec_opcode),
    .rd_addr  (dec_rd_addr),
    .has_data (dec_has_data),
    .is_fence (dec_fence),
    .illegal  (dec_illegal)
  );

  bp_be_dcache_pkt_s    pkt_in;
  bp_be_dcache_pkt_s    mem [buf_els_p];
  logic [ptr_w-1:0]     rptr, wptr;
  logic [cnt_w-1:0]     count, count_n;
  bp_be_encoder_state_e state;
  logic                 full, empty, accept, enq, deq;
  logic                 illegal_r, fence_done_r;

  assign pkt_in.opcode  = dec_opcode;
  assign pkt_in.data    = dec_has_data ? data_i : '0;
  assign pkt_in.vaddr   = vaddr_i;
  assign pkt_in.rd_addr = dec_rd_addr;

  assign full    = (count == cnt_w'(buf_els_p));
  assign empty   = (count == '0);
  assign ready_o = !full && (state == e_run);
  assign accept  = v_i && ready_o;
  // Flush wins over both a same-cycle accept and a same-cycle yumi
  assign enq     = accept && !flush_i && !dec_illegal && !dec_fence;
  assign deq     = pkt_yumi_i && !flush_i && !empty;

  assign pkt_v_o      = !empty;
  assign pkt_o        = mem[rptr];
  assign illegal_o    = illegal_r;
  assign fence_done_o = fence_done_r;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(buf_els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  // Occupancy after this edge; the FSM uses it to see the drain finishing
  always_comb begin
    count_n = count;
    if (flush_i) count_n = '0;
    else         count_n = count + cnt_w'(enq) - cnt_w'(deq);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= ptr_inc(wptr);
      if (deq) rptr <= ptr_inc(rptr);
      count <= count_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= pkt_in;
  end

  // FENCE completes on the edge where the buffer is (or becomes) empty,
  // so fence_done_o is seen the cycle the FIFO reads empty.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= e_run;
      illegal_r    <= 1'b0;
      fence_done_r <= 1'b0;
    end else begin
      illegal_r    <= accept && !flush_i && dec_illegal;
      fence_done_r <= 1'b0;
      case (state)
        e_run: begin
          if (accept && !flush_i && dec_fence) begin
            if (count_n == '0) fence_done_r <= 1'b1;
            else               state        <= e_drain;
          end
        end
        e_drain: begin
          if (count_n == '0) begin
            state        <= e_run;
            fence_done_r <= 1'b1;
          end
        end
        default: state <= e_run;
      endcase
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    pkt_yumi_i |-> pkt_v_o);
  a_buf_els_min: assert property (@(posedge clk_i) buf_els_p >= 1);

endmodule

// File: tb/tb_bp_be_dcache_pkt_encoder.sv
// tb_bp_be_dcache_pkt_encoder
// Directed bench for the dcache packet encoder with a queue-based reference
// model checked every cycle plus literal expectations on key cycles.

module tb_bp_be_dcache_pkt_encoder;
  import bp_be_dcache_pkt_encoder_pkg::*;

  localparam int buf_els = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              v, ready, flush, illegal, fence_done, pkt_v, yumi;
  logic [31:0]       instr;
  logic [38:0]       vaddr;
  logic [63:0]       data;
  bp_be_dcache_pkt_s pkt;

  int checks = 0;
  int errors = 0;
  int fence_count = 0;
  bit compare_on = 1'b0;

  always #5 clk = ~clk;

  bp_be_dcache_pkt_encoder #(.buf_els_p(buf_els)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .v_i          (v),
    .ready_o      (ready),
    .instr_i      (instr),
    .vaddr_i      (vaddr),
    .data_i       (data),
    .flush_i      (flush),
    .illegal_o    (illegal),
    .fence_done_o (fence_done),
    .pkt_v_o      (pkt_v),
    .pkt_o        (pkt),
    .pkt_yumi_i   (yumi)
  );

  typedef enum {k_pkt, k_fence, k_ill} kind_e;
  typedef struct {
    kind_e             kind;
    bp_be_dcache_pkt_s pkt;
  } dec_t;

  bp_be_dcache_pkt_s model_q[$];
  bit model_wait = 1'b0;
  bit exp_illegal = 1'b0;
  bit exp_fence_done = 1'b0;

  // Reference decode from the instruction-set tables
  function automatic dec_t model_decode(input logic [31:0] ins, input logic [38:0] va,
                                        input logic [63:0] d);
    dec_t r;
    bp_be_dcache_opcode_e loads [7];
    bp_be_dcache_opcode_e stores [4];
    bp_be_dcache_opcode_e amo_w [11];
    bp_be_dcache_opcode_e amo_d [11];
    logic [4:0] amo_f5 [11];
    logic [2:0] f3;
    logic [11:0] imm;
    loads  = '{e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
               e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu};
    stores = '{e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd};
    amo_f5 = '{5'd2, 5'd3, 5'd1, 5'd0, 5'd4, 5'd12, 5'd8, 5'd16, 5'd20, 5'd24, 5'd28};
    amo_w  = '{e_dcache_op_lrw, e_dcache_op_scw, e_dcache_op_amoswapw, e_dcache_op_amoaddw,
               e_dcache_op_amoxorw, e_dcache_op_amoandw, e_dcache_op_amoorw,
               e_dcache_op_amominw, e_dcache_op_amomaxw, e_dcache_op_amominuw,
               e_dcache_op_amomaxuw};
    amo_d  = '{e_dcache_op_lrd, e_dcache_op_scd, e_dcache_op_amoswapd, e_dcache_op_amoaddd,
               e_dcache_op_amoxord, e_dcache_op_amoandd, e_dcache_op_amoord,
               e_dcache_op_amomind, e_dcache_op_amomaxd, e_dcache_op_amominud,
               e_dcache_op_amomaxud};
    f3  = ins[14:12];
    imm = ins[31:20];
    r.kind = k_ill;
    r.pkt = '0;
    r.pkt.vaddr = va;
    if (ins[6:0] == 7'h03 && f3 != 3'd7) begin
      r.kind = k_pkt; r.pkt.opcode = loads[f3]; r.pkt.rd_addr = ins[11:7];
    end else if (ins[6:0] == 7'h23 && f3 < 3'd4) begin
      r.kind = k_pkt; r.pkt.opcode = stores[f3[1:0]]; r.pkt.data = d;
    end else if (ins[6:0] == 7'h07 && (f3 == 3'd2 || f3 == 3'd3)) begin
      r.kind = k_pkt; r.pkt.rd_addr = ins[11:7];
      r.pkt.opcode = (f3 == 3'd2) ? e_dcache_op_flw : e_dcache_op_fld;
    end else if (ins[6:0] == 7'h27 && (f3 == 3'd2 || f3 == 3'd3)) begin
      r.kind = k_pkt; r.pkt.data = d;
      r.pkt.opcode = (f3 == 3'd2) ? e_dcache_op_fsw : e_dcache_op_fsd;
    end else if (ins[6:0] == 7'h2F && (f3 == 3'd2 || f3 == 3'd3)) begin
      for (int i = 0; i < 11; i++) begin
        if (ins[31:27] == amo_f5[i] && !(i == 0 && ins[24:20] != 5'd0)) begin
          r.kind = k_pkt;
          r.pkt.opcode = (f3 == 3'd2) ? amo_w[i] : amo_d[i];
          r.pkt.rd_addr = ins[11:7];
          r.pkt.data = (i == 0) ? 64'd0 : d;
        end
      end
    end else if (ins[6:0] == 7'h0F && f3 == 3'd0) begin
      r.kind = k_fence;
    end else if (ins[6:0] == 7'h0F && f3 == 3'd2) begin
      r.kind = k_pkt;
      if      (imm == 12'd0) r.pkt.opcode = e_dcache_op_binval;
      else if (imm == 12'd1) r.pkt.opcode = e_dcache_op_bclean;
      else if (imm == 12'd2) r.pkt.opcode = e_dcache_op_bflush;
      else if (imm == 12'd4) r.pkt.opcode = e_dcache_op_bzero;
      else                   r.kind = k_ill;
    end
    return r;
  endfunction

  function automatic bit model_ready();
    return (model_q.size() < buf_els) && !model_wait;
  endfunction

  // Reference model advances on each rising edge
  always @(posedge clk) begin : model_step
    bit   acc;
    dec_t d;
    if (reset) begin
      model_q.delete();
      model_wait = 1'b0;
      exp_illegal = 1'b0;
      exp_fence_done = 1'b0;
    end else begin
      acc = v && model_ready();
      d = model_decode(instr, vaddr, data);
      exp_illegal = 1'b0;
      exp_fence_done = 1'b0;
      if (flush) begin
        model_q.delete();
        if (model_wait) begin
          model_wait = 1'b0;
          exp_fence_done = 1'b1;
        end
      end else begin
        if (yumi && model_q.size() > 0) void'(model_q.pop_front());
        if (acc) begin
          case (d.kind)
            k_pkt:   model_q.push_back(d.pkt);
            k_ill:   exp_illegal = 1'b1;
            default: if (model_q.size() == 0) exp_fence_done = 1'b1; else model_wait = 1'b1;
          endcase
        end else if (model_wait && model_q.size() == 0) begin
          model_wait = 1'b0;
          exp_fence_done = 1'b1;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (compare_on && !reset) begin
      if (fence_done) fence_count++;
      check_output("model ready", ready, model_ready());
      check_output("model pkt_v", pkt_v, model_q.size() > 0);
      if (model_q.size() > 0) check_output("model pkt", pkt, model_q[0]);
      check_output("model illegal", illegal, exp_illegal);
      check_output("model fence_done", fence_done, exp_fence_done);
    end
  end

  task automatic apply_stimulus(input logic v_n, input logic [31:0] instr_n,
                                input logic [38:0] va, input logic [63:0] d,
                                input logic yumi_n, input logic flush_n);
    v = v_n; instr = instr_n; vaddr = va; data = d; yumi = yumi_n; flush = flush_n;
    @(posedge clk); #1;
    v = 1'b0; yumi = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input logic yumi_n);
    apply_stimulus(1'b0, 32'h0, 39'h0, 64'h0, yumi_n, 1'b0);
  endtask

  localparam logic [31:0] i_lw     = 32'h0002A283;
  localparam logic [31:0] i_sd     = 32'h0062B023;
  localparam logic [31:0] i_amoadd = 32'h0062B3AF;
  localparam logic [31:0] i_lrw    = 32'h1002A1AF;
  localparam logic [31:0] i_sw     = 32'h0062A023;
  localparam logic [31:0] i_fence  = 32'h0FF0000F;
  localparam logic [31:0] i_czero  = 32'h0042A00F;
  localparam logic [31:0] i_cbad   = 32'h0032A00F;
  localparam logic [31:0] i_ldbad  = 32'h0002F283;
  localparam logic [31:0] i_amobad = 32'h2802A1AF;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; v = 1'b0; instr = '0; vaddr = '0; data = '0; flush = 1'b0; yumi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    compare_on = 1'b1;
    check_output("reset ready", ready, 1'b1);
    check_output("reset pkt_v", pkt_v, 1'b0);
    check_output("reset illegal", illegal, 1'b0);
    check_output("reset fence_done", fence_done, 1'b0);

    // lw x5 -> packet appears the next cycle with zeroed data
    apply_stimulus(1'b1, i_lw, 39'h1000, 64'hDEAD, 1'b0, 1'b0);
    check_output("lw pkt_v", pkt_v, 1'b1);
    check_output("lw opcode", pkt.opcode, e_dcache_op_lw);
    check_output("lw rd", pkt.rd_addr, 5'd5);
    check_output("lw vaddr", pkt.vaddr, 39'h1000);
    check_output("lw data", pkt.data, 64'h0);
    idle(1'b1);
    check_output("lw drained", pkt_v, 1'b0);

    // Fill the buffer, then drain in order while lr.w waits for space
    apply_stimulus(1'b1, i_sd, 39'h2000, 64'h1111, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_amoadd, 39'h2008, 64'h2222_0000_0000_2222, 1'b0, 1'b0);
    check_output("full ready", ready, 1'b0);
    apply_stimulus(1'b1, i_lrw, 39'h2010, 64'h3333, 1'b0, 1'b0);
    check_output("head sd", pkt.opcode, e_dcache_op_sd);
    check_output("sd rd", pkt.rd_addr, 5'd0);
    check_output("sd data", pkt.data, 64'h1111);
    apply_stimulus(1'b1, i_lrw, 39'h2010, 64'h3333, 1'b1, 1'b0);
    check_output("head amoaddd", pkt.opcode, e_dcache_op_amoaddd);
    check_output("amo rd", pkt.rd_addr, 5'd7);
    check_output("amo data", pkt.data, 64'h2222_0000_0000_2222);
    apply_stimulus(1'b1, i_lrw, 39'h2010, 64'h3333, 1'b1, 1'b0);
    check_output("head lrw", pkt.opcode, e_dcache_op_lrw);
    check_output("lrw rd", pkt.rd_addr, 5'd3);
    check_output("lrw data", pkt.data, 64'h0);
    idle(1'b1);
    check_output("lrw drained", pkt_v, 1'b0);

    // FENCE waits behind two stores
    fence_count = 0;
    apply_stimulus(1'b1, i_sw, 39'h3000, 64'hA, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_sw, 39'h3004, 64'hB, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, i_fence, 39'h0, 64'h0, 1'b0, 1'b0);
      check_output("fence stall ready", ready, 1'b0);
    end
    apply_stimulus(1'b1, i_fence, 39'h0, 64'h0, 1'b1, 1'b0);
    apply_stimulus(1'b1, i_fence, 39'h0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check_output("drain ready", ready, 1'b0);
      check_output("drain no done", fence_done, 1'b0);
    end
    idle(1'b1);
    check_output("fence done", fence_done, 1'b1);
    check_output("fence ready", ready, 1'b1);
    idle(1'b0);
    check_output("fence pulse count", fence_count, 1);

    // CBO zero then a reserved CBO immediate
    apply_stimulus(1'b1, i_czero, 39'h4000, 64'h55, 1'b0, 1'b0);
    check_output("cbo opcode", pkt.opcode, e_dcache_op_bzero);
    check_output("cbo rd", pkt.rd_addr, 5'd0);
    apply_stimulus(1'b1, i_cbad, 39'h4000, 64'h55, 1'b1, 1'b0);
    check_output("cbo bad illegal", illegal, 1'b1);
    check_output("cbo bad pkt_v", pkt_v, 1'b0);

    // Illegal encodings pulse illegal_o and leave the buffer empty
    apply_stimulus(1'b1, i_ldbad, 39'h5000, 64'h0, 1'b0, 1'b0);
    check_output("ld111 illegal", illegal, 1'b1);
    check_output("ld111 pkt_v", pkt_v, 1'b0);
    apply_stimulus(1'b1, i_amobad, 39'h5000, 64'h0, 1'b0, 1'b0);
    check_output("amo f5 illegal", illegal, 1'b1);
    check_output("amo f5 pkt_v", pkt_v, 1'b0);
    idle(1'b0);
    check_output("illegal cleared", illegal, 1'b0);

    // Flush against a full buffer with an instruction presented
    apply_stimulus(1'b1, i_lw, 39'h6000, 64'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_sd, 39'h6008, 64'h77, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_lw, 39'h6010, 64'h0, 1'b0, 1'b1);
    check_output("flush pkt_v", pkt_v, 1'b0);
    check_output("flush ready", ready, 1'b1);
    check_output("flush illegal", illegal, 1'b0);
    check_output("flush fence", fence_done, 1'b0);
    // Flush beats a same-cycle illegal accept
    apply_stimulus(1'b1, i_lw, 39'h6000, 64'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_ldbad, 39'h6000, 64'h0, 1'b0, 1'b1);
    check_output("flush drop illegal", illegal, 1'b0);
    check_output("flush drop pkt_v", pkt_v, 1'b0);

    // Flush while draining completes the FENCE
    apply_stimulus(1'b1, i_sw, 39'h7000, 64'h1, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_fence, 39'h0, 64'h0, 1'b0, 1'b0);
    check_output("drain2 ready", ready, 1'b0);
    apply_stimulus(1'b0, 32'h0, 39'h0, 64'h0, 1'b0, 1'b1);
    check_output("flush drain done", fence_done, 1'b1);
    check_output("flush drain ready", ready, 1'b1);

    // Reset while draining loses the packet and the pending pulse
    apply_stimulus(1'b1, i_sw, 39'h8000, 64'h2, 1'b0, 1'b0);
    apply_stimulus(1'b1, i_fence, 39'h0, 64'h0, 1'b0, 1'b0);
    check_output("drain3 ready", ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("reset drain pkt_v", pkt_v, 1'b0);
    check_output("reset drain ready", ready, 1'b1);
    check_output("reset drain fence", fence_done, 1'b0);
    idle(1'b0);
    check_output("post reset fence", fence_done, 1'b0);

    idle(1'b0);
    compare_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
